// File: rtl/id_ctrl_pipe_if.sv
// IF/ID-to-EX handshake and registered control bundle of the decode stage.
// master = upstream/EX side, slave = the decode stage itself.
interface id_ctrl_pipe_if;
    logic        if_valid;
    logic [31:0] instr;
    logic        flush;
    logic        id_ready;
    logic        ex_valid;
    logic        ex_RegWrite;
    logic        ex_MemWrite;
    logic        ex_ALUSrc;
    logic [5:0]  ex_EXTOp;
    logic [4:0]  ex_ALUOp;
    logic [2:0]  ex_NPCOp;
    logic [1:0]  ex_WDSel;
    logic [2:0]  ex_DMType;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mdu_en;
    logic [2:0]  ex_mdu_op;
    logic        ex_illegal;

    modport master (
        output if_valid, instr, flush,
        input  id_ready, ex_valid, ex_RegWrite, ex_MemWrite, ex_ALUSrc, ex_EXTOp,
               ex_ALUOp, ex_NPCOp, ex_WDSel, ex_DMType, ex_rs1, ex_rs2, ex_rd,
               ex_mdu_en, ex_mdu_op, ex_illegal
    );

    modport slave (
        input  if_valid, instr, flush,
        output id_ready, ex_valid, ex_RegWrite, ex_MemWrite, ex_ALUSrc, ex_EXTOp,
               ex_ALUOp, ex_NPCOp, ex_WDSel, ex_DMType, ex_rs1, ex_rs2, ex_rd,
               ex_mdu_en, ex_mdu_op, ex_illegal
    );
endinterface

// File: rtl/id_ctrl_pipe.sv
// RV32I(+M) decode stage with registered ID/EX control bundle, load-use
// hazard detection and MDU occupancy stall.
module id_ctrl_pipe #(
    parameter int unsigned ENABLE_M = 1,
    parameter int unsigned MUL_LAT  = 2,
    parameter int unsigned DIV_LAT  = 16
) (
    input  logic          clk,
    input  logic          rst,
    id_ctrl_pipe_if.slave bus
);
    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [5:0] EXT_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_I     = 6'b010000;
    localparam logic [5:0] EXT_S     = 6'b001000;
    localparam logic [5:0] EXT_B     = 6'b000100;
    localparam logic [5:0] EXT_U     = 6'b000010;
    localparam logic [5:0] EXT_J     = 6'b000001;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic [5:0] ext_op;
        logic [4:0] alu_op;
        logic [2:0] npc_op;
        logic [1:0] wd_sel;
        logic [2:0] dm_type;
        logic       mdu_en;
        logic [2:0] mdu_op;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {RUN, MDU_WAIT} state_t;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;

    assign instr  = bus.instr;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    ctrl_t  dec;
    logic   use_rs1, use_rs2, bad;

    always_comb begin
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        bad     = 1'b0;
        case (opcode)
            OP_R: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec.reg_write = 1'b1;
                if (funct7 == 7'b0000001) begin
                    if (ENABLE_M != 0) begin
                        dec.mdu_en = 1'b1;
                        dec.mdu_op = funct3;
                    end else begin
                        bad = 1'b1;
                    end
                end else if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec.alu_op = 5'b00011;
                        3'b001:  dec.alu_op = 5'b01111;
                        3'b010:  dec.alu_op = 5'b01010;
                        3'b011:  dec.alu_op = 5'b01011;
                        3'b100:  dec.alu_op = 5'b01100;
                        3'b101:  dec.alu_op = 5'b10000;
                        3'b110:  dec.alu_op = 5'b01101;
                        default: dec.alu_op = 5'b01110;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec.alu_op = 5'b00100;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec.alu_op = 5'b10001;
                end else begin
                    bad = 1'b1;
                end
            end
            OP_IMM: begin
                use_rs1       = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.ext_op    = EXT_I;
                case (funct3)
                    3'b000: dec.alu_op = 5'b00011;
                    3'b010: dec.alu_op = 5'b01010;
                    3'b011: dec.alu_op = 5'b01011;
                    3'b100: dec.alu_op = 5'b01100;
                    3'b110: dec.alu_op = 5'b01101;
                    3'b111: dec.alu_op = 5'b01110;
                    3'b001: begin
                        dec.ext_op = EXT_SHAMT;
                        dec.alu_op = 5'b01111;
                        bad        = (funct7 != 7'b0000000);
                    end
                    default: begin
                        dec.ext_op = EXT_SHAMT;
                        if (funct7 == 7'b0000000)      dec.alu_op = 5'b10000;
                        else if (funct7 == 7'b0100000) dec.alu_op = 5'b10001;
                        else                           bad = 1'b1;
                    end
                endcase
            end
            OP_LOAD: begin
                use_rs1       = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.ext_op    = EXT_I;
                dec.alu_op    = 5'b00011;
                dec.wd_sel    = 2'b01;
                case (funct3)
                    3'b000:  dec.dm_type = 3'b011;
                    3'b001:  dec.dm_type = 3'b001;
                    3'b010:  dec.dm_type = 3'b000;
                    3'b100:  dec.dm_type = 3'b100;
                    3'b101:  dec.dm_type = 3'b010;
                    default: bad = 1'b1;
                endcase
            end
            OP_STORE: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.ext_op    = EXT_S;
                dec.alu_op    = 5'b00011;
                case (funct3)
                    3'b000:  dec.dm_type = 3'b011;
                    3'b001:  dec.dm_type = 3'b001;
                    3'b010:  dec.dm_type = 3'b000;
                    default: bad = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec.npc_op = 3'b001;
                dec.ext_op = EXT_B;
                case (funct3)
                    3'b000:  dec.alu_op = 5'b00100;
                    3'b001:  dec.alu_op = 5'b00101;
                    3'b100:  dec.alu_op = 5'b00110;
                    3'b101:  dec.alu_op = 5'b00111;
                    3'b110:  dec.alu_op = 5'b01000;
                    3'b111:  dec.alu_op = 5'b01001;
                    default: bad = 1'b1;
                endcase
            end
            OP_LUI, OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.ext_op    = EXT_U;
                dec.alu_op    = (opcode == OP_LUI) ? 5'b00001 : 5'b00010;
            end
            OP_JAL: begin
                dec.reg_write = 1'b1;
                dec.ext_op    = EXT_J;
                dec.npc_op    = 3'b010;
                dec.wd_sel    = 2'b10;
            end
            OP_JALR: begin
                use_rs1       = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.ext_op    = EXT_I;
                dec.alu_op    = 5'b00011;
                dec.npc_op    = 3'b100;
                dec.wd_sel    = 2'b10;
                bad           = (funct3 != 3'b000);
            end
            default: bad = 1'b1;
        endcase
        // Unrecognised words carry no side effects and read no registers.
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
            use_rs1     = 1'b0;
            use_rs2     = 1'b0;
        end
    end

    logic             ex_valid_q;
    ctrl_t            ex_ctrl_q;
    logic [4:0]       ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic [CNT_W-1:0] busy_cnt, busy_cnt_nxt;
    state_t           state, state_nxt;
    logic             lu, id_ready, accept;

    assign lu = ex_valid_q && (ex_ctrl_q.wd_sel == 2'b01) && (ex_rd_q != 5'd0) &&
                ((use_rs1 && (rs1 == ex_rd_q)) || (use_rs2 && (rs2 == ex_rd_q)));
    assign id_ready = !rst && !lu && (busy_cnt == '0);
    assign accept   = bus.if_valid && id_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            busy_cnt <= '0;
        end else begin
            state    <= state_nxt;
            busy_cnt <= busy_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy_cnt_nxt = busy_cnt;
        case (state)
            RUN: begin
                if (accept && dec.mdu_en) begin
                    state_nxt    = MDU_WAIT;
                    busy_cnt_nxt = funct3[2] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                end
            end
            default: begin
                if (busy_cnt != '0) busy_cnt_nxt = busy_cnt - 1'b1;
                if (busy_cnt <= CNT_W'(1)) state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush || !accept) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
        end else begin
            ex_valid_q <= 1'b1;
            ex_ctrl_q  <= dec;
            ex_rs1_q   <= rs1;
            ex_rs2_q   <= rs2;
            ex_rd_q    <= rd;
        end
    end

    assign bus.id_ready    = id_ready;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_RegWrite = ex_ctrl_q.reg_write;
    assign bus.ex_MemWrite = ex_ctrl_q.mem_write;
    assign bus.ex_ALUSrc   = ex_ctrl_q.alu_src;
    assign bus.ex_EXTOp    = ex_ctrl_q.ext_op;
    assign bus.ex_ALUOp    = ex_ctrl_q.alu_op;
    assign bus.ex_NPCOp    = ex_ctrl_q.npc_op;
    assign bus.ex_WDSel    = ex_ctrl_q.wd_sel;
    assign bus.ex_DMType   = ex_ctrl_q.dm_type;
    assign bus.ex_rs1      = ex_rs1_q;
    assign bus.ex_rs2      = ex_rs2_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_mdu_en   = ex_ctrl_q.mdu_en;
    assign bus.ex_mdu_op   = ex_ctrl_q.mdu_op;
    assign bus.ex_illegal  = ex_ctrl_q.illegal;
endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Bench for id_ctrl_pipe: directed scenarios plus random instruction streams
// against a mnemonic-level decode table and a timestamp-based stall model.
module tb_id_ctrl_pipe;
    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned DIV_LAT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ctrl_pipe_if bus ();
    id_ctrl_pipe_if bus_nom ();

    id_ctrl_pipe #(.ENABLE_M(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
    id_ctrl_pipe #(.ENABLE_M(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut_nom (
        .clk(clk), .rst(rst), .bus(bus_nom.slave));

    assign bus_nom.if_valid = bus.if_valid;
    assign bus_nom.instr    = bus.instr;
    assign bus_nom.flush    = bus.flush;

    typedef struct packed {
        logic       valid, rw, mw, alusrc;
        logic [5:0] ext;
        logic [4:0] alu;
        logic [2:0] npc;
        logic [1:0] wd;
        logic [2:0] dm;
        logic [4:0] rs1, rs2, rd;
        logic       mdu_en;
        logic [2:0] mdu_op;
        logic       illegal;
    } bundle_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode tables indexed by funct3
    logic [4:0] ALU_RI [8] = '{5'b00011, 5'b01111, 5'b01010, 5'b01011,
                               5'b01100, 5'b10000, 5'b01101, 5'b01110};
    logic [4:0] ALU_BR [8] = '{5'b00100, 5'b00101, 5'b00000, 5'b00000,
                               5'b00110, 5'b00111, 5'b01000, 5'b01001};
    logic [2:0] DM_LD  [8] = '{3'b011, 3'b001, 3'b000, 3'b000, 3'b100, 3'b010, 3'b000, 3'b000};

    function automatic void ref_decode(input logic [31:0] w, input bit m_on,
                                       output bundle_t b, output bit u1, output bit u2);
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        bit ok = 1'b1;
        b = '0; u1 = 1'b0; u2 = 1'b0;
        b.valid = 1'b1; b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7];
        case (op)
            7'b0110011: begin
                u1 = 1; u2 = 1; b.rw = 1;
                if (f7 == 7'b0000001) begin ok = m_on; b.mdu_en = 1; b.mdu_op = f3; end
                else if (f7 == 7'b0000000) b.alu = ALU_RI[f3];
                else if (f7 == 7'b0100000 && f3 == 3'd0) b.alu = 5'b00100;
                else if (f7 == 7'b0100000 && f3 == 3'd5) b.alu = 5'b10001;
                else ok = 0;
            end
            7'b0010011: begin
                u1 = 1; b.rw = 1; b.alusrc = 1; b.alu = ALU_RI[f3];
                b.ext = (f3 == 3'd1 || f3 == 3'd5) ? 6'b100000 : 6'b010000;
                if (f3 == 3'd1 && f7 != 7'd0) ok = 0;
                if (f3 == 3'd5 && f7 == 7'b0100000) b.alu = 5'b10001;
                else if (f3 == 3'd5 && f7 != 7'd0) ok = 0;
            end
            7'b0000011: begin
                u1 = 1; b.rw = 1; b.alusrc = 1; b.ext = 6'b010000; b.alu = 5'b00011;
                b.wd = 2'b01; b.dm = DM_LD[f3];
                ok = (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
            end
            7'b0100011: begin
                u1 = 1; u2 = 1; b.mw = 1; b.alusrc = 1; b.ext = 6'b001000; b.alu = 5'b00011;
                b.dm = DM_LD[f3]; ok = (f3 <= 3'd2);
            end
            7'b1100011: begin
                u1 = 1; u2 = 1; b.npc = 3'b001; b.ext = 6'b000100; b.alu = ALU_BR[f3];
                ok = (f3 != 3'd2 && f3 != 3'd3);
            end
            7'b0110111: begin b.rw = 1; b.alusrc = 1; b.ext = 6'b000010; b.alu = 5'b00001; end
            7'b0010111: begin b.rw = 1; b.alusrc = 1; b.ext = 6'b000010; b.alu = 5'b00010; end
            7'b1101111: begin b.rw = 1; b.ext = 6'b000001; b.npc = 3'b010; b.wd = 2'b10; end
            7'b1100111: begin
                u1 = 1; b.rw = 1; b.alusrc = 1; b.ext = 6'b010000; b.alu = 5'b00011;
                b.npc = 3'b100; b.wd = 2'b10; ok = (f3 == 3'd0);
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            b = '0; b.valid = 1'b1; b.illegal = 1'b1;
            b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7];
            u1 = 1'b0; u2 = 1'b0;
        end
    endfunction

    function automatic bundle_t obs_main();
        bundle_t o;
        o.valid = bus.ex_valid;     o.rw = bus.ex_RegWrite;  o.mw = bus.ex_MemWrite;
        o.alusrc = bus.ex_ALUSrc;   o.ext = bus.ex_EXTOp;    o.alu = bus.ex_ALUOp;
        o.npc = bus.ex_NPCOp;       o.wd = bus.ex_WDSel;     o.dm = bus.ex_DMType;
        o.rs1 = bus.ex_rs1;         o.rs2 = bus.ex_rs2;      o.rd = bus.ex_rd;
        o.mdu_en = bus.ex_mdu_en;   o.mdu_op = bus.ex_mdu_op; o.illegal = bus.ex_illegal;
        return o;
    endfunction

    // Model state: what EX should hold, and the first edge a new accept is allowed
    bundle_t     m_ex = '0;
    int unsigned edge_n = 0;
    int unsigned free_edge = 0;
    bit          obs_ready;
    bit          exp_ready_last;

    task automatic step(input bit r, input bit v, input logic [31:0] w, input bit f);
        bundle_t d;
        bit u1, u2, lu, exp_ready, acc;
        @(negedge clk);
        rst = r; bus.if_valid = v; bus.instr = w; bus.flush = f;
        #1;
        ref_decode(w, 1'b1, d, u1, u2);
        lu = m_ex.valid && m_ex.wd == 2'b01 && m_ex.rd != 5'd0 &&
             ((u1 && w[19:15] == m_ex.rd) || (u2 && w[24:20] == m_ex.rd));
        exp_ready = !r && !lu && (edge_n >= free_edge);
        obs_ready = bus.id_ready;
        exp_ready_last = exp_ready;
        check_eq("id_ready", 64'(bus.id_ready), 64'(exp_ready));
        acc = v && exp_ready;
        if (r) begin
            m_ex = '0;
            free_edge = 0;
        end else begin
            if (acc && d.mdu_en) free_edge = edge_n + (w[14] ? DIV_LAT : MUL_LAT) + 1;
            m_ex = (f || !acc) ? bundle_t'('0) : d;
        end
        @(posedge clk);
        edge_n++;
        #1;
        check_eq("ex_bundle", 64'(obs_main()), 64'(m_ex));
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] b, input logic [4:0] a,
                                          input logic [2:0] f3, input logic [4:0] d);
        return {f7, b, a, f3, d, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] a, input logic [2:0] f3,
                                          input logic [4:0] d, input logic [6:0] op);
        return {imm, a, f3, d, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] b, input logic [4:0] a,
                                          input logic [2:0] f3);
        return {imm[11:5], b, a, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  a   = 5'($urandom_range(0, 3));
        logic [4:0]  b   = 5'($urandom_range(0, 3));
        logic [4:0]  d   = 5'($urandom_range(0, 3));
        logic [2:0]  f3  = 3'($urandom);
        logic [11:0] imm = 12'($urandom);
        logic [6:0]  f7s [3] = '{7'b0000000, 7'b0100000, 7'b0000001};
        case ($urandom_range(0, 11))
            0:  return enc_r(f7s[$urandom_range(0, 2)], b, a, f3, d);
            1:  return enc_i(imm, a, f3, d, 7'b0010011);
            2, 11: return enc_i(imm, a, f3, d, 7'b0000011);
            3:  return enc_s(imm, b, a, f3);
            4:  return {imm[11:5], b, a, f3, imm[4:0], 7'b1100011};
            5:  return {imm, a, f3, d, 7'b0110111};
            6:  return {imm, a, f3, d, 7'b0010111};
            7:  return {imm, a, f3, d, 7'b1101111};
            8:  return enc_i(imm, a, ($urandom_range(0, 3) == 0) ? f3 : 3'd0, d, 7'b1100111);
            9:  return enc_r(7'b0000001, b, a, ($urandom_range(0, 3) == 0) ? f3 : {1'b0, f3[1:0]}, d);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] add1, addi, sw1, lw5, add_dep, add_x0, lw0, divi, muli, w;
        int unsigned n;
        bit hold, v, r, f;
        add1    = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3);
        addi    = enc_i(12'd5, 5'd0, 3'd0, 5'd4, 7'b0010011);
        sw1     = enc_s(12'd0, 5'd4, 5'd3, 3'd2);
        lw5     = enc_i(12'd0, 5'd1, 3'd2, 5'd5, 7'b0000011);
        add_dep = enc_r(7'd0, 5'd2, 5'd5, 3'd0, 5'd6);
        add_x0  = enc_r(7'd0, 5'd2, 5'd0, 3'd0, 5'd6);
        lw0     = enc_i(12'd0, 5'd1, 3'd2, 5'd0, 7'b0000011);
        divi    = enc_r(7'b0000001, 5'd9, 5'd8, 3'b100, 5'd7);
        muli    = enc_r(7'b0000001, 5'd3, 5'd2, 3'b000, 5'd1);
        bus.if_valid = 1'b0; bus.instr = '0; bus.flush = 1'b0;

        step(1, 0, '0, 0);
        step(1, 0, '0, 0);

        // Back-to-back issue
        step(0, 1, add1, 0);
        step(0, 1, addi, 0);
        check_eq("addi_extop", 64'(bus.ex_EXTOp), 64'(6'b010000));
        step(0, 1, sw1, 0);
        check_eq("sw_memwrite", 64'(bus.ex_MemWrite), 64'(1'b1));

        // Load-use: one stall cycle, then the dependent add issues
        step(0, 1, lw5, 0);
        step(0, 1, add_dep, 0);
        check_eq("lu_stall_ready", 64'(obs_ready), 64'(1'b0));
        check_eq("lu_bubble", 64'(bus.ex_valid), 64'(1'b0));
        step(0, 1, add_dep, 0);
        check_eq("lu_issue_ready", 64'(obs_ready), 64'(1'b1));
        step(0, 1, lw5, 0);
        step(0, 1, add_x0, 0);
        step(0, 1, lw0, 0);
        step(0, 1, add_x0, 0);

        // Divide occupancy, then multiply
        step(0, 1, divi, 0);
        check_eq("div_mdu", 64'({bus.ex_mdu_en, bus.ex_mdu_op}), 64'(4'b1100));
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 1, addi, 0);
            if (obs_ready) break;
            n++;
        end
        check_eq("div_stall_cycles", 64'(n), 64'(DIV_LAT));
        step(0, 1, muli, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 1, addi, 0);
            if (obs_ready) break;
            n++;
        end
        check_eq("mul_stall_cycles", 64'(n), 64'(MUL_LAT));

        // Flush during a load-use stall, and flush while the MDU is busy
        step(0, 1, lw5, 0);
        step(0, 1, add_dep, 1);
        check_eq("flush_bubble", 64'(bus.ex_valid), 64'(1'b0));
        step(0, 1, add_dep, 0);
        step(0, 1, muli, 0);
        step(0, 1, addi, 1);
        step(0, 1, addi, 1);
        step(0, 1, addi, 0);
        check_eq("flush_busy_ready", 64'(obs_ready), 64'(1'b1));

        // Illegal encodings
        step(0, 1, 32'h0000007F, 0);
        step(0, 1, enc_i(12'd0, 5'd1, 3'd1, 5'd1, 7'b1100111), 0);
        check_eq("jalr_f3_illegal", 64'({bus.ex_illegal, bus.ex_valid, bus.ex_RegWrite, bus.ex_MemWrite}),
                 64'(4'b1100));
        step(0, 1, muli, 0);
        check_eq("nom_mul_illegal", 64'({bus_nom.ex_valid, bus_nom.ex_illegal, bus_nom.ex_RegWrite,
                                         bus_nom.ex_MemWrite, bus_nom.ex_mdu_en}), 64'(5'b11000));
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);

        // Reset while the divider has 9 cycles left
        step(0, 1, divi, 0);
        for (int i = 0; i < 7; i++) step(0, 0, '0, 0);
        step(1, 1, addi, 0);
        check_eq("rst_ready", 64'(obs_ready), 64'(1'b0));
        step(0, 1, addi, 0);
        check_eq("rst_release_ready", 64'(obs_ready), 64'(1'b1));

        // Random streams; upstream holds an instruction until it is accepted
        hold = 1'b0; v = 1'b0; w = '0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                w = rand_instr();
            end
            f = ($urandom_range(0, 15) == 0);
            step(r, v, w, f);
            hold = v && !exp_ready_last && !r;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
